// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg -- shared definitions for the instruction-fetch stage.
//   RESET_PC_DEFAULT : default PC loaded on reset
//   NOP_INSTR        : word presented when no valid instruction is available
//   fetch_state_e    : 2-bit fetch FSM encoding (IDLE, REQ, DROP, HOLD)
//   align_word()     : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package if_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/next_pc_mux.sv
// -----------------------------------------------------------------------------
// next_pc_mux -- candidate next-PC values for the fetch stage.
//   pc             in  : current fetch PC
//   branch_taken   in  : branch redirect request (wins over jump)
//   branch_target  in  : branch destination (byte offset ignored)
//   jump           in  : jump redirect request
//   jump_target    in  : jump destination (byte offset ignored)
//   seq_pc         out : pc + 4 (32-bit wrap)
//   redirect       out : any redirect requested this cycle
//   redirect_pc    out : word-aligned destination of the redirect
// -----------------------------------------------------------------------------
module next_pc_mux
  import if_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] seq_pc,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  assign seq_pc      = pc + 32'd4;
  assign redirect    = branch_taken | jump;
  assign redirect_pc = align_word(branch_taken ? branch_target : jump_target);

endmodule

// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch -- instruction fetch stage with a single outstanding memory request.
//   clk           in  : clock, all state updates on the rising edge
//   rst           in  : asynchronous active-low reset
//   PC_Write      in  : 1 = hold PC and presented word, 0 = advance
//   branch_taken  in  / branch_target in : branch redirect (priority)
//   jump          in  / jump_target   in : jump redirect
//   imem_req      out / imem_addr     out : memory request, word address
//   imem_ready    in  / imem_rdata    in  : memory response strobe, data
//   instr_add     out : pc + 4 for IF/ID
//   instr         out : instruction word for IF/ID (NOP when none valid)
//   fetch_stall   out : high when no valid word is presented
// -----------------------------------------------------------------------------
module if_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_Write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_add,
  output logic [31:0] instr,
  output logic        fetch_stall
);

  fetch_state_e state, state_d;
  logic [31:0]  pc, pc_d;
  logic [31:0]  hold_buf, hold_buf_d;
  // Address of the request still in flight when a redirect hit it; the memory
  // must see a stable address until it answers, even though pc has moved on.
  logic [31:0]  drop_addr, drop_addr_d;

  logic [31:0]  seq_pc;
  logic         redirect;
  logic [31:0]  redirect_pc;

  next_pc_mux u_next_pc_mux (
    .pc            (pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .seq_pc        (seq_pc),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc)
  );

  assign instr_add = seq_pc;

  // NOTE: hold_buf and drop_addr are plain registers (not a memory array), so
  // they are reset alongside the FSM to give a fully defined post-reset state.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      hold_buf  <= 32'h0;
      drop_addr <= 32'h0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      hold_buf  <= hold_buf_d;
      drop_addr <= drop_addr_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state;
    pc_d        = pc;
    hold_buf_d  = hold_buf;
    drop_addr_d = drop_addr;
    imem_req    = 1'b0;
    imem_addr   = pc;
    instr       = NOP_INSTR;
    fetch_stall = 1'b1;

    unique case (state)
      IDLE: begin
        state_d = REQ;
        if (redirect) pc_d = redirect_pc;
      end

      REQ: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_d = redirect_pc;
          if (!imem_ready) begin
            // Response still owed for the old pc: wait it out and discard it.
            state_d     = DROP;
            drop_addr_d = pc;
          end
        end else if (imem_ready) begin
          instr       = imem_rdata;
          fetch_stall = 1'b0;
          if (PC_Write) begin
            hold_buf_d = imem_rdata;
            state_d    = HOLD;
          end else begin
            pc_d = seq_pc;
          end
        end
      end

      HOLD: begin
        instr       = hold_buf;
        fetch_stall = 1'b0;
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = REQ;
        end else if (!PC_Write) begin
          pc_d    = seq_pc;
          state_d = REQ;
        end
      end

      DROP: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr;
        if (redirect) pc_d = redirect_pc;
        // The stale response ends the drop even if a new redirect arrives in
        // the same cycle; otherwise we would wait for a response never coming.
        if (imem_ready) state_d = REQ;
      end

      default: state_d = IDLE;
    endcase

    // A redirect cycle always presents a bubble, whatever the state.
    if (redirect) begin
      instr       = NOP_INSTR;
      fetch_stall = 1'b0;
    end
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: PC_Write  input  1  stall from hazard unit; 1'b1 = hold PC and presented word, 1'b0 = advance (same polarity as IF_ID_Write).
REQ-005 SHALL have ports: branch_taken  input  1; branch_target  input  32  branch redirect request and target.
REQ-006 SHALL have ports: jump  input  1; jump_target  input  32  jump redirect request and target.
REQ-007 SHALL have ports: imem_req  output  1; imem_addr  output  32  instruction memory request and word address.
REQ-008 SHALL have ports: imem_ready  input  1; imem_rdata  input  32  memory response strobe and data.
REQ-009 SHALL have ports: instr_add  output  32; instr  output  32  PC+4 and instruction word presented to IF/ID.
REQ-010 SHALL have port: fetch_stall  output  1  high when no valid word is presented; ORed into IF_ID_Write by the hazard unit.

Function
REQ-011 SHALL implement FSM states IDLE, REQ, DROP, HOLD.
REQ-012 IDLE: imem_req=0, fetch_stall=1; next state REQ unconditionally.
REQ-013 REQ: imem_req=1, imem_addr=pc; imem_addr SHALL stay stable until imem_ready.
REQ-014 REQ with imem_ready and no redirect: instr=imem_rdata, fetch_stall=0 same cycle (zero-cycle data path, combinational from imem_rdata).
REQ-015 REQ, imem_ready, PC_Write=0: pc <= pc+4, remain REQ (new request next cycle).
REQ-016 REQ, imem_ready, PC_Write=1: capture imem_rdata in hold_buf, go HOLD, pc unchanged.
REQ-017 HOLD: imem_req=0, instr=hold_buf, fetch_stall=0; on PC_Write=0 pc <= pc+4 and go REQ.
REQ-018 Redirect = branch_taken | jump; target = branch_target if branch_taken else jump_target (branch has priority); target[1:0] forced to 2'b00.
REQ-019 Redirect cycle, any state: instr=32'h0000_0000 (NOP), fetch_stall=0, redirect acts regardless of PC_Write.
REQ-020 Redirect in IDLE, HOLD, or REQ with imem_ready: pc <= target, next state REQ, hold_buf discarded.
REQ-021 Redirect in REQ without imem_ready: pc <= target, go DROP (outstanding response discarded).
REQ-022 DROP: imem_req=1 with the original address held stable, instr=0, fetch_stall=1; on imem_ready discard data, go REQ.
REQ-023 Redirect while in DROP: pc <= new target; remain DROP.
REQ-024 instr_add SHALL always equal pc+4 (32-bit wrap; 32'hFFFF_FFFC+4 = 32'h0).
REQ-025 When fetch_stall=1 and no redirect, instr SHALL be 32'h0.

Reset
REQ-026 rst low SHALL asynchronously force pc=RESET_PC, state=IDLE, hold_buf=0, the held DROP address=0.
REQ-027 During and immediately after reset: imem_req=0, instr=0, instr_add=RESET_PC+4, fetch_stall=1.
REQ-028 Reset mid-request SHALL abandon the transaction; first request after release is RESET_PC, issued from the second rising edge.

Structure
REQ-029 Shared package if_pkg SHALL hold RESET_PC default, NOP_INSTR (32'h0), state encoding (2-bit: IDLE, REQ, DROP, HOLD).
REQ-030 Next-PC selection (pc+4 / branch / jump, alignment masking) SHALL be a sub-module next_pc_mux; FSM, pc, hold_buf, and DROP-address registers stay in if_fetch.

Verification
REQ-031 Reset release, imem_ready tied 1, PC_Write=0 -> imem_addr sequence 0,4,8,12; instr matches memory; instr_add = addr+4.
REQ-032 imem_ready low 3 cycles at addr 0x8 -> fetch_stall=1, instr=0, imem_addr=0x8 held stable; ready -> word presented, next addr 0xC.
REQ-033 Word at 0x10 returned while PC_Write=1 for 2 cycles -> HOLD, instr=hold_buf stable, imem_req=0; release -> addr 0x14.
REQ-034 branch_taken=1, target 0x103, and jump=1 in same cycle, ready=1 -> instr=0 that cycle, next imem_addr=0x100.
REQ-035 jump to 0x40 while waiting at 0x20 -> DROP, addr 0x20 held; on ready data discarded (instr=0), next request 0x40.
REQ-036 rst asserted mid-wait at 0x30 -> imem_req=0 immediately, pc=RESET_PC; first request after release at RESET_PC.
